mult_issue_queue: RTL and testbench
===================================

Name: mult_issue_queue

Overview:
- Upstream feeder for the posit16 multiplier datapath (p16 operands → f32 multiply → p16 result).
- The multiplier accepts one operand pair per transaction (`input_valid` pulse) and signals completion with `output_valid` a few cycles later. It has no backpressure and no queuing.
- This block buffers operand pairs from a valid/ready producer in a small FIFO and issues them to the multiplier strictly one at a time.
- It captures each result and presents it on a valid/ready consumer port, with a timeout watchdog on each transaction.

Parameters:
- WIDTH, 16, operand/result width in bits (posit16).
- DEPTH, 4, operand FIFO entries; must be a power of two, ≥2.
- TIMEOUT, 15, max cycles waited in WAIT for `mul_output_valid` before abandoning the transaction.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- reset, input, 1, asynchronous active-low reset.
- in_valid, input, 1, producer has an operand pair.
- in_ready, output, 1, FIFO can accept a pair this cycle.
- in_a, input, WIDTH, operand A.
- in_b, input, WIDTH, operand B.
- mul_input_valid, output, 1, one-cycle issue pulse to the multiplier.
- mul_a, output, WIDTH, operand A to the multiplier (registered).
- mul_b, output, WIDTH, operand B to the multiplier (registered).
- mul_output_valid, input, 1, multiplier result valid.
- mul_r, input, WIDTH, multiplier result.
- out_valid, output, 1, result available.
- out_ready, input, 1, consumer accepts result.
- out_r, output, WIDTH, result (registered).
- count, output, $clog2(DEPTH)+1, FIFO occupancy.
- err, output, 1, sticky timeout flag.
- err_clr, input, 1, synchronous clear of `err`.

Behaviour:
- Reset (reset==0, asynchronous):
  - FIFO empty, `count`=0, FSM=IDLE, timer=0.
  - `in_ready`=1 after reset releases.
  - `mul_input_valid`=0, `mul_a`=`mul_b`=0, `out_valid`=0, `out_r`=0, `err`=0.
  - Reset mid-transaction abandons the in-flight operation and drops all queued pairs. A later `mul_output_valid` is ignored unless the FSM is in WAIT.
- FIFO:
  - `in_ready` = (`count` != DEPTH), combinational from registered `count`.
  - Push when `in_valid` && `in_ready`.
  - Pop occurs only on the IDLE→ISSUE transition.
  - Simultaneous push and pop leaves `count` unchanged.
  - Read/write pointers carry one extra wrap bit; full/empty are derived from the pointers.
  - Order is strictly FIFO.
- FSM states: IDLE, ISSUE, WAIT, DRAIN.
  - IDLE: if `count` != 0, load `mul_a`/`mul_b` from the FIFO head, pop, and go to ISSUE. Otherwise stay.
  - ISSUE: `mul_input_valid`=1 for exactly this cycle; clear timer; go to WAIT.
  - WAIT: `mul_input_valid`=0.
    - If `mul_output_valid`==1: `out_r` <= `mul_r`, `out_valid` <= 1, go to DRAIN.
    - Else if timer == TIMEOUT-1: `err` <= 1, drop the transaction, go to IDLE.
    - Else timer++.
  - DRAIN: `out_valid` held with `out_r` stable until `out_ready`==1. On the handshake, `out_valid` <= 0 and go to IDLE.
- `mul_output_valid` outside WAIT is ignored.
- `mul_a`/`mul_b` hold their last issued values outside ISSUE.
- Latency: a pair pushed at edge N into an empty FIFO with FSM in IDLE gives `mul_input_valid` high in cycle N+2. A result seen in WAIT at cycle M gives `out_valid` high from cycle M+1.
- Throughput: one transaction per (2 + multiplier latency + 1 + drain wait) cycles. No overlap of transactions.
- `err`: set on timeout, cleared by `err_clr`. A timeout and `err_clr` in the same cycle leaves `err`=1.
- `count` is registered and always reflects the current FIFO occupancy.

Decomposition:
- Shared package `mult_pkg`: `issue_state_t` enum {IDLE, ISSUE, WAIT, DRAIN} as reg [1:0], plus the default WIDTH/DEPTH/TIMEOUT constants.
- One sub-module: `sync_fifo` (parameters WIDTH*2, DEPTH; ports push/pop/full/empty/count/head data), instantiated once.
- FSM, timer and result register live in the top module.

Test Plan:
- Bench uses a stub multiplier with latency L=3 returning {a[7:0],b[7:0]}.
- Single op: push (0x4000, 0x5000) with `out_ready`=1 → one `mul_input_valid` pulse 2 cycles later; `out_valid` for 1 cycle with `out_r`=0x0000; `count` returns to 0.
- Fill: push 5 pairs back-to-back ((0x1122,0x3344)…), `out_ready`=1 → `in_ready` drops when `count`==4 after one issue; all 5 results come out in order (0x2244, …); no pulse overlap.
- Backpressure: `out_ready`=0 for 10 cycles after the first result → `out_r` stable and `out_valid` held. No second `mul_input_valid` until the handshake, then it occurs 2 cycles later.
- Timeout: stub never asserts `mul_output_valid` → `err`=1 exactly TIMEOUT cycles after WAIT is entered; next queued pair issues. `err_clr` pulse clears `err`; simultaneous timeout+`err_clr` keeps `err`=1.
- Reset mid-op: assert reset in WAIT with 3 pairs queued → outputs immediately 0, `count`=0. A stale `mul_output_valid` after release produces no `out_valid`.
- Spurious `mul_output_valid` in IDLE/DRAIN → no change to `out_r`/`out_valid`.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and default sizing for the posit16 multiplier issue queue.
package mult_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } issue_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Operand-pair FIFO with wrap-bit pointers and a registered occupancy count.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [WIDTH-1:0]           rdata
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q, count_q;
    logic             push_ok, pop_ok;

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign count   = count_q;
    // Head is read combinationally so the issuer can load it on the same edge it pops.
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/mult_issue_queue.sv
// Buffers operand pairs and issues them one at a time to a fixed-latency
// multiplier, holding each result on a valid/ready port with a timeout watchdog.
module mult_issue_queue
    import mult_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_a,
    input  logic [WIDTH-1:0]       in_b,
    output logic                   mul_input_valid,
    output logic [WIDTH-1:0]       mul_a,
    output logic [WIDTH-1:0]       mul_b,
    input  logic                   mul_output_valid,
    input  logic [WIDTH-1:0]       mul_r,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_r,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err,
    input  logic                   err_clr
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    issue_state_t       state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [WIDTH-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [WIDTH-1:0]   out_r_q, out_r_d;
    logic               out_valid_q, out_valid_d;
    logic               err_q, err_d;
    logic               timeout;
    logic               pop;
    logic               fifo_full, fifo_empty;
    logic [2*WIDTH-1:0] head;

    sync_fifo #(.WIDTH(2*WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid && !fifo_full),
        .pop   (pop),
        .wdata ({in_a, in_b}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count),
        .rdata (head)
    );

    assign in_ready        = (count != (AW+1)'(DEPTH));
    assign mul_input_valid = (state_q == ISSUE);
    assign mul_a           = mul_a_q;
    assign mul_b           = mul_b_q;
    assign out_valid       = out_valid_q;
    assign out_r           = out_r_q;
    assign err             = err_q;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        out_r_d     = out_r_q;
        out_valid_d = out_valid_q;
        timeout     = 1'b0;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    mul_a_d = head[2*WIDTH-1:WIDTH];
                    mul_b_d = head[WIDTH-1:0];
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (mul_output_valid) begin
                    out_r_d     = mul_r;
                    out_valid_d = 1'b1;
                    state_d     = DRAIN;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A timeout wins over a clear arriving in the same cycle.
        err_d = timeout ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            out_r_q     <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            out_r_q     <= out_r_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_mult_issue_queue.sv
// Directed bench for mult_issue_queue with a latency-3 stub multiplier and a queue-based reference model.
module tb_mult_issue_queue;
    localparam int W  = 16;
    localparam int D  = 4;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a, in_b;
    logic          mul_input_valid;
    logic [W-1:0]  mul_a, mul_b;
    logic          mul_output_valid;
    logic [W-1:0]  mul_r;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_r;
    logic [2:0]    count;
    logic          err;
    logic          err_clr;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic chk_en = 1'b0;

    mult_issue_queue #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_a             (in_a),
        .in_b             (in_b),
        .mul_input_valid  (mul_input_valid),
        .mul_a            (mul_a),
        .mul_b            (mul_b),
        .mul_output_valid (mul_output_valid),
        .mul_r            (mul_r),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_r            (out_r),
        .count            (count),
        .err              (err),
        .err_clr          (err_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub multiplier: result {a[7:0],b[7:0]} three cycles after the issue pulse; not reset by the DUT reset.
    logic          stub_en = 1'b1;
    logic [2:0]    sv = 3'b000;
    logic [W-1:0]  sd0 = '0, sd1 = '0, sd2 = '0;
    logic          spur_ov = 1'b0;
    logic [W-1:0]  spur_r = '0;
    always @(posedge clk) begin
        sv  <= {sv[1:0], mul_input_valid & stub_en};
        sd0 <= {mul_a[7:0], mul_b[7:0]};
        sd1 <= sd0;
        sd2 <= sd1;
    end
    assign mul_output_valid = sv[2] | spur_ov;
    assign mul_r            = spur_ov ? spur_r : sd2;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Reference model: a queue of pending pairs plus the current transaction phase.
    logic [31:0] m_q[$];
    int          m_phase, m_wait, m_n;
    logic        m_ov, m_err, m_push, m_tmo;
    logic [W-1:0] m_r, m_a, m_b;
    logic [31:0] m_pair;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_q.delete();
            m_phase = 0; m_wait = 0; m_ov = 0; m_err = 0;
            m_r = '0; m_a = '0; m_b = '0;
        end else begin
            m_n    = m_q.size();
            m_push = in_valid && (m_n != D);
            m_tmo  = 1'b0;
            case (m_phase)
                0: if (m_n != 0) begin
                       m_pair = m_q.pop_front();
                       m_a = m_pair[31:16]; m_b = m_pair[15:0];
                       m_phase = 1;
                   end
                1: begin m_wait = 0; m_phase = 2; end
                2: if (mul_output_valid) begin
                       m_r = mul_r; m_ov = 1'b1; m_phase = 3;
                   end else if (m_wait == TO - 1) begin
                       m_tmo = 1'b1; m_phase = 0;
                   end else m_wait++;
                default: if (out_ready) begin m_ov = 1'b0; m_phase = 0; end
            endcase
            if (m_push) m_q.push_back({in_a, in_b});
            if (m_tmo) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready",  in_ready, m_q.size() != D);
            chk("count",     count, m_q.size());
            chk("mul_iv",    mul_input_valid, m_phase == 1);
            chk("mul_a",     mul_a, m_a);
            chk("mul_b",     mul_b, m_b);
            chk("out_valid", out_valid, m_ov);
            chk("out_r",     out_r, m_r);
            chk("err",       err, m_err);
        end
    end

    task automatic wait_until(input int sel, input string nm);
        int i;
        for (i = 0; i < 200; i++) begin
            if ((sel == 0 && mul_input_valid) || (sel == 1 && out_valid) || (sel == 2 && err)) break;
            @(negedge clk);
        end
        if (i == 200) begin
            tests++; fails++;
            $display("FAIL wait_%s: got no event, expected one within 200 cycles", nm);
        end
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1; in_a = a; in_b = b;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    logic [W-1:0] fill_exp [5] = '{16'h2244, 16'h3355, 16'h4466, 16'h5577, 16'h6688};

    initial begin
        int c0;
        reset = 1'b0; in_valid = 0; in_a = '0; in_b = '0; out_ready = 0; err_clr = 0;
        repeat (2) @(negedge clk);
        chk("rst_mul_iv", mul_input_valid, 0);
        chk("rst_count",  count, 0);
        chk("rst_out",    {out_valid, out_r, err}, 0);
        chk("rst_mul_ab", {mul_a, mul_b}, 0);
        reset = 1'b1; chk_en = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", in_ready, 1);

        // single operation
        out_ready = 1'b1;
        push(16'h4000, 16'h5000);
        chk("single_no_early_pulse", mul_input_valid, 0);
        @(negedge clk);
        chk("single_pulse", mul_input_valid, 1);
        chk("single_mul_a", mul_a, 16'h4000);
        wait_until(1, "single_out");
        chk("single_out_r", out_r, 16'h0000);
        @(negedge clk);
        chk("single_out_drop", out_valid, 0);
        chk("single_count0", count, 0);

        // fill: five back-to-back pairs
        for (int i = 0; i < 5; i++) push(16'h1122 + 16'(i) * 16'h1111, 16'h3344 + 16'(i) * 16'h1111);
        chk("fill_count4", count, 4);
        chk("fill_not_ready", in_ready, 0);
        for (int j = 0; j < 5; j++) begin
            wait_until(1, "fill_out");
            chk("fill_order", out_r, fill_exp[j]);
            @(negedge clk);
        end

        // backpressure
        out_ready = 1'b0;
        push(16'hAB01, 16'hCD02);
        push(16'h1203, 16'h3404);
        wait_until(1, "bp_out");
        chk("bp_first", out_r, 16'h0102);
        repeat (10) begin
            @(negedge clk);
            chk("bp_hold", {out_valid, out_r, mul_input_valid}, {1'b1, 16'h0102, 1'b0});
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_no_pulse_yet", mul_input_valid, 0);
        @(negedge clk);
        chk("bp_pulse_after_hs", mul_input_valid, 1);
        wait_until(1, "bp_second");
        chk("bp_second", out_r, 16'h0304);
        @(negedge clk);

        // timeout
        stub_en = 1'b0;
        push(16'h0001, 16'h0002);
        push(16'h0003, 16'h0004);
        wait_until(0, "to_pulse");
        c0 = cyc;
        @(negedge clk);
        wait_until(2, "to_err");
        chk("to_delay_from_wait", cyc - (c0 + 1), TO);
        @(negedge clk);
        wait_until(0, "to_next_issue");
        chk("to_next_mul_a", mul_a, 16'h0003);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr", err, 0);
        repeat (14) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("to_and_clr_keeps_err", err, 1);
        @(negedge clk);
        chk("err_sticky", err, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_clr2", err, 0);
        stub_en = 1'b1;

        // spurious result in IDLE and DRAIN
        spur_ov = 1'b1; spur_r = 16'hDEAD;
        @(negedge clk);
        spur_ov = 1'b0;
        chk("spur_idle", {out_valid, out_r}, {1'b0, 16'h0304});
        out_ready = 1'b0;
        push(16'h0A0B, 16'h0C0D);
        wait_until(1, "spur_out");
        spur_ov = 1'b1; spur_r = 16'hBEEF;
        @(negedge clk);
        spur_ov = 1'b0;
        chk("spur_drain", {out_valid, out_r}, {1'b1, 16'h0B0D});
        out_ready = 1'b1;
        @(negedge clk);

        // reset in WAIT with three pairs queued
        for (int i = 0; i < 5; i++) push(16'h7000 + 16'(i), 16'h8000 + 16'(i));
        wait_until(0, "rst_pulse");
        chk("rst_queued3", count, 3);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_outs", {mul_input_valid, out_valid, out_r, err}, 0);
        chk("mid_rst_mul_ab", {mul_a, mul_b}, 0);
        chk("mid_rst_count", count, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("stale_ignored", {out_valid, mul_input_valid}, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected one before 200000");
        $fatal(1);
    end

endmodule
